// File: rtl/int_ex_pkg.sv
// Shared constants, ALU op enum, decoded-op struct and decode helpers for the int_ex integer unit.
package int_ex_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;

    localparam logic [6:0] F7_BASE      = 7'b0000000;
    localparam logic [6:0] F7_ALT       = 7'b0100000;
    localparam logic [6:0] F7_MULDIV    = 7'b0000001;

    localparam logic [2:0] F3_ADD       = 3'b000;
    localparam logic [2:0] F3_SLL       = 3'b001;
    localparam logic [2:0] F3_SLT       = 3'b010;
    localparam logic [2:0] F3_SLTU      = 3'b011;
    localparam logic [2:0] F3_XOR       = 3'b100;
    localparam logic [2:0] F3_SR        = 3'b101;
    localparam logic [2:0] F3_OR        = 3'b110;
    localparam logic [2:0] F3_AND       = 3'b111;

    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    isWord;
        logic    useImm;
    } dec_op_t;

    typedef enum logic {ST_IDLE, ST_MUL_BUSY} mul_state_e;

    // Anything not recognised decodes to ALU_NONE, which the ALU turns into a zero result.
    function automatic dec_op_t decodeOp(input logic [6:0] opcode, input logic [2:0] funct3,
                                         input logic [11:0] imm);
        dec_op_t    d;
        logic [6:0] f7;
        d.op     = ALU_NONE;
        d.isWord = 1'b0;
        d.useImm = 1'b0;
        f7       = imm[11:5];
        case (opcode)
            OPC_OP, OPC_OP32: begin
                d.isWord = (opcode == OPC_OP32);
                case (funct3)
                    F3_ADD:  if (f7 == F7_BASE) d.op = ALU_ADD;
                             else if (f7 == F7_ALT) d.op = ALU_SUB;
                    F3_SLL:  if (f7 == F7_BASE) d.op = ALU_SLL;
                    F3_SR:   if (f7 == F7_BASE) d.op = ALU_SRL;
                             else if (f7 == F7_ALT) d.op = ALU_SRA;
                    F3_SLT:  if (f7 == F7_BASE && !d.isWord) d.op = ALU_SLT;
                    F3_SLTU: if (f7 == F7_BASE && !d.isWord) d.op = ALU_SLTU;
                    F3_XOR:  if (f7 == F7_BASE && !d.isWord) d.op = ALU_XOR;
                    F3_OR:   if (f7 == F7_BASE && !d.isWord) d.op = ALU_OR;
                    F3_AND:  if (f7 == F7_BASE && !d.isWord) d.op = ALU_AND;
                    default: d.op = ALU_NONE;
                endcase
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                d.isWord = (opcode == OPC_OPIMM32);
                d.useImm = 1'b1;
                case (funct3)
                    F3_ADD:  d.op = ALU_ADD;
                    F3_SLL:  d.op = ALU_SLL;
                    F3_SR:   d.op = imm[10] ? ALU_SRA : ALU_SRL;
                    F3_SLT:  if (!d.isWord) d.op = ALU_SLT;
                    F3_SLTU: if (!d.isWord) d.op = ALU_SLTU;
                    F3_XOR:  if (!d.isWord) d.op = ALU_XOR;
                    F3_OR:   if (!d.isWord) d.op = ALU_OR;
                    F3_AND:  if (!d.isWord) d.op = ALU_AND;
                    default: d.op = ALU_NONE;
                endcase
            end
            default: d.op = ALU_NONE;
        endcase
        return d;
    endfunction

    // Returns {isMul, isWord} for the MUL / MULW encodings.
    function automatic logic [1:0] mulDecode(input logic [6:0] opcode, input logic [2:0] funct3,
                                             input logic [11:0] imm);
        logic hit;
        hit = ((opcode == OPC_OP) || (opcode == OPC_OP32)) &&
              (funct3 == F3_ADD) && (imm[11:5] == F7_MULDIV);
        return {hit, hit & (opcode == OPC_OP32)};
    endfunction

endpackage

// File: rtl/int_ex_if.sv
// Issue (rs2ex), forward (int2rs) and ROB write (ex2rob) bundle around the int_ex unit.
interface int_ex_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
);
    logic [6:0]       opcode_rs2ex;
    logic [2:0]       funct3_rs2ex;
    logic [TAG_W-1:0] tag_rs2ex;
    logic [XLEN-1:0]  rs1_rs2ex;
    logic [XLEN-1:0]  rs2_rs2ex;
    logic [TAG_W-1:0] rd_rs2ex;
    logic [11:0]      imm_rs2ex;
    logic             valid_rs2ex;
    logic             stop_ex2rs;
    logic [XLEN-1:0]  result_int2rs;
    logic [TAG_W-1:0] rd_int2rs;
    logic             valid_int2rs;
    logic [XLEN-1:0]  result_ex2rob;
    logic [TAG_W-1:0] tag_ex2rob;
    logic             valid_ex2rob;
    logic             stall_rob2ex;

    modport slave (
        input  opcode_rs2ex, funct3_rs2ex, tag_rs2ex, rs1_rs2ex, rs2_rs2ex, rd_rs2ex,
               imm_rs2ex, valid_rs2ex, stall_rob2ex,
        output stop_ex2rs, result_int2rs, rd_int2rs, valid_int2rs,
               result_ex2rob, tag_ex2rob, valid_ex2rob
    );

    modport master (
        output opcode_rs2ex, funct3_rs2ex, tag_rs2ex, rs1_rs2ex, rs2_rs2ex, rd_rs2ex,
               imm_rs2ex, valid_rs2ex, stall_rob2ex,
        input  stop_ex2rs, result_int2rs, rd_int2rs, valid_int2rs,
               result_ex2rob, tag_ex2rob, valid_ex2rob
    );
endinterface

// File: rtl/int_ex_alu.sv
// int_ex_alu: combinational decode + single-cycle ALU (the int_alu of the unit).
// Word ops work on the low 32 bits and sign-extend the 32-bit result.
module int_ex_alu
    import int_ex_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [11:0]     i_imm,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_result
);
    dec_op_t         w_dec;
    logic [XLEN-1:0] w_opB;
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_res64;
    logic [31:0]     w_res32;
    logic [31:0]     w_a32;
    logic [31:0]     w_b32;

    always_comb begin
        w_dec   = decodeOp(i_opcode, i_funct3, i_imm);
        w_opB   = w_dec.useImm ? {{(XLEN-12){i_imm[11]}}, i_imm} : i_rs2;
        w_a32   = i_rs1[31:0];
        w_b32   = w_opB[31:0];
        w_shamt = w_dec.isWord ? {1'b0, w_opB[4:0]} : w_opB[5:0];
        w_res64 = '0;
        w_res32 = '0;
        case (w_dec.op)
            ALU_ADD:  w_res64 = i_rs1 + w_opB;
            ALU_SUB:  w_res64 = i_rs1 - w_opB;
            ALU_SLL:  w_res64 = i_rs1 << w_shamt;
            ALU_SLT:  w_res64 = {{(XLEN-1){1'b0}}, ($signed(i_rs1) < $signed(w_opB))};
            ALU_SLTU: w_res64 = {{(XLEN-1){1'b0}}, (i_rs1 < w_opB)};
            ALU_XOR:  w_res64 = i_rs1 ^ w_opB;
            ALU_SRL:  w_res64 = i_rs1 >> w_shamt;
            ALU_SRA:  w_res64 = $signed(i_rs1) >>> w_shamt;
            ALU_OR:   w_res64 = i_rs1 | w_opB;
            ALU_AND:  w_res64 = i_rs1 & w_opB;
            default:  w_res64 = '0;
        endcase
        case (w_dec.op)
            ALU_ADD:  w_res32 = w_a32 + w_b32;
            ALU_SUB:  w_res32 = w_a32 - w_b32;
            ALU_SLL:  w_res32 = w_a32 << w_shamt[4:0];
            ALU_SRL:  w_res32 = w_a32 >> w_shamt[4:0];
            ALU_SRA:  w_res32 = $signed(w_a32) >>> w_shamt[4:0];
            default:  w_res32 = '0;
        endcase
        o_result = w_dec.isWord ? {{(XLEN-32){w_res32[31]}}, w_res32} : w_res64;
    end
endmodule

// File: rtl/int_ex.sv
// int_ex: integer execution unit behind the rs2ex issue port; one result register feeds RS and ROB.
// Define INT_EX_MUL_EN to add the multi-cycle MUL/MULW path and its FSM.
module int_ex
    import int_ex_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TAG_W   = 6
`ifdef INT_EX_MUL_EN
    ,
    parameter int MUL_LAT = 4
`endif
) (
    input  logic    clk,
    input  logic    res_n,
    int_ex_if.slave bus
);
    logic [XLEN-1:0]  w_aluResult;
    logic             w_drain;
    logic             w_busy;
    logic             w_stop;
    logic             w_accept;
    logic             w_aluLoad;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] r_rd;
    logic             r_full;
    logic             r_fwd;

    int_ex_alu #(.XLEN(XLEN)) u_alu (
        .i_opcode (bus.opcode_rs2ex),
        .i_funct3 (bus.funct3_rs2ex),
        .i_imm    (bus.imm_rs2ex),
        .i_rs1    (bus.rs1_rs2ex),
        .i_rs2    (bus.rs2_rs2ex),
        .o_result (w_aluResult)
    );

    assign w_drain  = r_full & ~bus.stall_rob2ex;
    assign w_stop   = (r_full & bus.stall_rob2ex) | w_busy;
    assign w_accept = bus.valid_rs2ex & ~w_stop;

`ifdef INT_EX_MUL_EN
    localparam int CNT_W = $clog2(MUL_LAT);

    mul_state_e       r_state;
    mul_state_e       w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [1:0]       w_mulDec;
    logic             w_mulStart;
    logic             w_mulDone;
    logic [XLEN-1:0]  r_mulA;
    logic [XLEN-1:0]  r_mulB;
    logic             r_mulWord;
    logic [TAG_W-1:0] r_mulTag;
    logic [TAG_W-1:0] r_mulRd;
    logic [XLEN-1:0]  w_prod;
    logic [XLEN-1:0]  w_mulResult;

    assign w_mulDec    = mulDecode(bus.opcode_rs2ex, bus.funct3_rs2ex, bus.imm_rs2ex);
    assign w_busy      = (r_state == ST_MUL_BUSY);
    assign w_mulStart  = w_accept & w_mulDec[1];
    assign w_aluLoad   = w_accept & ~w_mulDec[1];
    assign w_prod      = r_mulA * r_mulB;
    assign w_mulResult = r_mulWord ? {{(XLEN-32){w_prod[31]}}, w_prod[31:0]} : w_prod;

    // A finished MUL waits at count 0 until the result register is free or draining.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_mulDone   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mulStart) begin
                    w_stateNext = ST_MUL_BUSY;
                    w_cntNext   = CNT_W'(MUL_LAT - 1);
                end
            end
            ST_MUL_BUSY: begin
                if (r_cnt != '0) begin
                    w_cntNext = r_cnt - CNT_W'(1);
                end else if (!r_full || w_drain) begin
                    w_mulDone   = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mulA    <= '0;
            r_mulB    <= '0;
            r_mulWord <= 1'b0;
            r_mulTag  <= '0;
            r_mulRd   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            if (w_mulStart) begin
                r_mulA    <= bus.rs1_rs2ex;
                r_mulB    <= bus.rs2_rs2ex;
                r_mulWord <= w_mulDec[0];
                r_mulTag  <= bus.tag_rs2ex;
                r_mulRd   <= bus.rd_rs2ex;
            end
        end
    end
`else
    assign w_busy    = 1'b0;
    assign w_aluLoad = w_accept;
`endif

    // A load in the same cycle as a drain simply overwrites, giving one result per cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_result <= '0;
            r_tag    <= '0;
            r_rd     <= '0;
            r_full   <= 1'b0;
            r_fwd    <= 1'b0;
        end else begin
            r_fwd <= 1'b0;
            if (w_aluLoad) begin
                r_result <= w_aluResult;
                r_tag    <= bus.tag_rs2ex;
                r_rd     <= bus.rd_rs2ex;
                r_full   <= 1'b1;
                r_fwd    <= 1'b1;
            end
`ifdef INT_EX_MUL_EN
            else if (w_mulDone) begin
                r_result <= w_mulResult;
                r_tag    <= r_mulTag;
                r_rd     <= r_mulRd;
                r_full   <= 1'b1;
                r_fwd    <= 1'b1;
            end
`endif
            else if (w_drain) begin
                r_full <= 1'b0;
            end
        end
    end

    assign bus.stop_ex2rs    = w_stop;
    assign bus.result_int2rs = r_result;
    assign bus.rd_int2rs     = r_rd;
    assign bus.valid_int2rs  = r_fwd;
    assign bus.result_ex2rob = r_result;
    assign bus.tag_ex2rob    = r_tag;
    assign bus.valid_ex2rob  = r_full;
endmodule

// File: tb/tb_int_ex.sv
// Directed self-checking bench for int_ex; MUL expectations follow INT_EX_MUL_EN.
module tb_int_ex;
    localparam int MUL_LAT = 4;
    localparam logic [6:0] OP      = 7'b0110011;
    localparam logic [6:0] OPIMM   = 7'b0010011;
    localparam logic [6:0] OP32    = 7'b0111011;
    localparam logic [6:0] OPIMM32 = 7'b0011011;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    logic clk;
    logic res_n;
    int   tests;
    int   failed;
    vec_t vecs[12];

    int_ex_if #(.XLEN(64), .TAG_W(6)) bus ();

    int_ex dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [11:0] imm,
                         input logic [5:0] tag, input logic [5:0] rd,
                         input logic [63:0] a, input logic [63:0] b);
        bus.opcode_rs2ex = opc;
        bus.funct3_rs2ex = f3;
        bus.imm_rs2ex    = imm;
        bus.tag_rs2ex    = tag;
        bus.rd_rs2ex     = rd;
        bus.rs1_rs2ex    = a;
        bus.rs2_rs2ex    = b;
        bus.valid_rs2ex  = 1'b1;
    endtask

    task automatic test_reset();
        drive(7'd0, 3'd0, 12'd0, 6'd0, 6'd0, 64'd0, 64'd0);
        bus.valid_rs2ex  = 1'b0;
        bus.stall_rob2ex = 1'b0;
        res_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (bus.valid_ex2rob !== 1'b0) begin failed++; $display("[TB] FAIL rst_valid_rob: got %b expected 0", bus.valid_ex2rob); end
        tests++; if (bus.valid_int2rs !== 1'b0) begin failed++; $display("[TB] FAIL rst_valid_rs: got %b expected 0", bus.valid_int2rs); end
        tests++; if (bus.stop_ex2rs !== 1'b0) begin failed++; $display("[TB] FAIL rst_stop: got %b expected 0", bus.stop_ex2rs); end
        tests++; if (bus.result_ex2rob !== 64'd0) begin failed++; $display("[TB] FAIL rst_result: got %h expected 0", bus.result_ex2rob); end
        tests++; if (bus.tag_ex2rob !== 6'd0) begin failed++; $display("[TB] FAIL rst_tag: got %h expected 0", bus.tag_ex2rob); end
        res_n = 1'b1;
        step();
        tests++; if (bus.valid_ex2rob !== 1'b0) begin failed++; $display("[TB] FAIL post_rst_valid: got %b expected 0", bus.valid_ex2rob); end
    endtask

    task automatic test_add();
        drive(OP, 3'b000, 12'h000, 6'd13, 6'd1, 64'd530, 64'd714);
        step();
        bus.valid_rs2ex = 1'b0;
        tests++; if (bus.result_ex2rob !== 64'd1244) begin failed++; $display("[TB] FAIL add_rob: got %0d expected 1244", bus.result_ex2rob); end
        tests++; if (bus.result_int2rs !== 64'd1244) begin failed++; $display("[TB] FAIL add_rs: got %0d expected 1244", bus.result_int2rs); end
        tests++; if (bus.tag_ex2rob !== 6'd13) begin failed++; $display("[TB] FAIL add_tag: got %0d expected 13", bus.tag_ex2rob); end
        tests++; if (bus.rd_int2rs !== 6'd1) begin failed++; $display("[TB] FAIL add_rd: got %0d expected 1", bus.rd_int2rs); end
        tests++; if (bus.valid_ex2rob !== 1'b1) begin failed++; $display("[TB] FAIL add_valid_rob: got %b expected 1", bus.valid_ex2rob); end
        tests++; if (bus.valid_int2rs !== 1'b1) begin failed++; $display("[TB] FAIL add_valid_rs: got %b expected 1", bus.valid_int2rs); end
        step();
        tests++; if (bus.valid_int2rs !== 1'b0) begin failed++; $display("[TB] FAIL add_valid_rs_end: got %b expected 0", bus.valid_int2rs); end
        tests++; if (bus.valid_ex2rob !== 1'b0) begin failed++; $display("[TB] FAIL add_valid_rob_end: got %b expected 0", bus.valid_ex2rob); end
    endtask

    task automatic test_back_to_back();
        drive(OP, 3'b000, 12'h400, 6'd2, 6'd3, 64'd859, 64'd721);
        #1;
        tests++; if (bus.stop_ex2rs !== 1'b0) begin failed++; $display("[TB] FAIL b2b_stop0: got %b expected 0", bus.stop_ex2rs); end
        @(negedge clk);
        step();
        drive(OPIMM, 3'b000, 12'hFFF, 6'd4, 6'd5, 64'd323, 64'd0);
        #1;
        tests++; if (bus.result_ex2rob !== 64'd138) begin failed++; $display("[TB] FAIL sub_result: got %0d expected 138", bus.result_ex2rob); end
        tests++; if (bus.stop_ex2rs !== 1'b0) begin failed++; $display("[TB] FAIL b2b_stop1: got %b expected 0", bus.stop_ex2rs); end
        @(negedge clk);
        bus.valid_rs2ex = 1'b0;
        tests++; if (bus.result_ex2rob !== 64'd322) begin failed++; $display("[TB] FAIL addi_result: got %0d expected 322", bus.result_ex2rob); end
        tests++; if (bus.tag_ex2rob !== 6'd4) begin failed++; $display("[TB] FAIL addi_tag: got %0d expected 4", bus.tag_ex2rob); end
        tests++; if (bus.valid_int2rs !== 1'b1) begin failed++; $display("[TB] FAIL addi_fwd: got %b expected 1", bus.valid_int2rs); end
        step();
    endtask

    task automatic test_word_ops();
        drive(OP32, 3'b000, 12'h000, 6'd6, 6'd7, 64'h0000_0000_7FFF_FFFF, 64'd1);
        step();
        drive(OPIMM, 3'b101, 12'h402, 6'd8, 6'd9, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0);
        tests++; if (bus.result_ex2rob !== 64'hFFFF_FFFF_8000_0000) begin failed++; $display("[TB] FAIL addw: got %h expected ffffffff80000000", bus.result_ex2rob); end
        step();
        bus.valid_rs2ex = 1'b0;
        tests++; if (bus.result_ex2rob !== 64'hFFFF_FFFF_FFFF_FFFC) begin failed++; $display("[TB] FAIL srai: got %h expected fffffffffffffffc", bus.result_ex2rob); end
        step();
    endtask

    task automatic test_alu_ops();
        vecs[0]  = '{OP,    3'b010, 12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
        vecs[1]  = '{OP,    3'b011, 12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
        vecs[2]  = '{OP,    3'b001, 12'h000, 64'd1, 64'd65, 64'd2};
        vecs[3]  = '{OP32,  3'b101, 12'h000, 64'h0000_0000_8000_0000, 64'd4, 64'h0000_0000_0800_0000};
        vecs[4]  = '{OP32,  3'b101, 12'h400, 64'h0000_0000_8000_0000, 64'd36, 64'hFFFF_FFFF_F800_0000};
        vecs[5]  = '{OPIMM, 3'b100, 12'hF0F, 64'h0000_0000_0000_00FF, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF0};
        vecs[6]  = '{OP,    3'b111, 12'h000, 64'hF0F0, 64'hFF00, 64'hF000};
        vecs[7]  = '{OP32,  3'b000, 12'h400, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8]  = '{7'b1111111, 3'b000, 12'h000, 64'd5, 64'd6, 64'd0};
        vecs[9]  = '{OPIMM, 3'b011, 12'hFFF, 64'd5, 64'd0, 64'd1};
        vecs[10] = '{OP,    3'b101, 12'h400, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[11] = '{OP,    3'b000, 12'h7E0, 64'd5, 64'd6, 64'd0};
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].opc, vecs[i].f3, vecs[i].imm, 6'(i + 20), 6'(i), vecs[i].a, vecs[i].b);
            step();
            tests++; if (bus.result_ex2rob !== vecs[i].exp) begin failed++; $display("[TB] FAIL alu_vec%0d: got %h expected %h", i, bus.result_ex2rob, vecs[i].exp); end
            tests++; if (bus.valid_int2rs !== 1'b1) begin failed++; $display("[TB] FAIL alu_fwd%0d: got %b expected 1", i, bus.valid_int2rs); end
        end
        bus.valid_rs2ex = 1'b0;
        step();
    endtask

    task automatic test_stall();
        drive(OP, 3'b000, 12'h000, 6'd5, 6'd2, 64'd10, 64'd20);
        step();
        drive(OP, 3'b000, 12'h000, 6'd6, 6'd3, 64'd1, 64'd1);
        bus.stall_rob2ex = 1'b1;
        #1;
        tests++; if (bus.valid_int2rs !== 1'b1) begin failed++; $display("[TB] FAIL stall_first_fwd: got %b expected 1", bus.valid_int2rs); end
        for (int k = 0; k < 3; k++) begin
            tests++; if (bus.stop_ex2rs !== 1'b1) begin failed++; $display("[TB] FAIL stall_stop%0d: got %b expected 1", k, bus.stop_ex2rs); end
            step();
            tests++; if (bus.valid_ex2rob !== 1'b1) begin failed++; $display("[TB] FAIL stall_hold%0d: got %b expected 1", k, bus.valid_ex2rob); end
            tests++; if (bus.result_ex2rob !== 64'd30) begin failed++; $display("[TB] FAIL stall_result%0d: got %0d expected 30", k, bus.result_ex2rob); end
            tests++; if (bus.valid_int2rs !== 1'b0) begin failed++; $display("[TB] FAIL stall_fwd%0d: got %b expected 0", k, bus.valid_int2rs); end
        end
        bus.stall_rob2ex = 1'b0;
        #1;
        tests++; if (bus.stop_ex2rs !== 1'b0) begin failed++; $display("[TB] FAIL release_stop: got %b expected 0", bus.stop_ex2rs); end
        @(negedge clk);
        step();
        bus.valid_rs2ex = 1'b0;
        tests++; if (bus.result_ex2rob !== 64'd2) begin failed++; $display("[TB] FAIL release_result: got %0d expected 2", bus.result_ex2rob); end
        tests++; if (bus.tag_ex2rob !== 6'd6) begin failed++; $display("[TB] FAIL release_tag: got %0d expected 6", bus.tag_ex2rob); end
        tests++; if (bus.valid_int2rs !== 1'b1) begin failed++; $display("[TB] FAIL release_fwd: got %b expected 1", bus.valid_int2rs); end
        step();
        tests++; if (bus.valid_ex2rob !== 1'b0) begin failed++; $display("[TB] FAIL release_drain: got %b expected 0", bus.valid_ex2rob); end
    endtask

    task automatic test_mul();
        logic [6:0]  opcs [2];
        logic [63:0] as   [2];
        logic [63:0] bs   [2];
        logic [63:0] exps [2];
        opcs[0] = OP;   as[0] = 64'd3;                  bs[0] = 64'd5;
        opcs[1] = OP32; as[1] = 64'hFFFF_FFFF_FFFF_FFFE; bs[1] = 64'd3;
`ifdef INT_EX_MUL_EN
        exps[0] = 64'd15;
        exps[1] = 64'hFFFF_FFFF_FFFF_FFFA;
`else
        exps[0] = 64'd0;
        exps[1] = 64'd0;
`endif
        for (int i = 0; i < 2; i++) begin
            drive(opcs[i], 3'b000, 12'h020, 6'(7 + i), 6'(4 + i), as[i], bs[i]);
            #1;
            tests++; if (bus.stop_ex2rs !== 1'b0) begin failed++; $display("[TB] FAIL mul%0d_stop_pre: got %b expected 0", i, bus.stop_ex2rs); end
            @(negedge clk);
            step();
`ifdef INT_EX_MUL_EN
            drive(OP, 3'b000, 12'h000, 6'd20, 6'd2, 64'd40, 64'd2);
            for (int k = 0; k < MUL_LAT; k++) begin
                tests++; if (bus.stop_ex2rs !== 1'b1) begin failed++; $display("[TB] FAIL mul%0d_busy%0d: got %b expected 1", i, k, bus.stop_ex2rs); end
                tests++; if (bus.valid_ex2rob !== 1'b0) begin failed++; $display("[TB] FAIL mul%0d_early%0d: got %b expected 0", i, k, bus.valid_ex2rob); end
                if (k < MUL_LAT - 1) step();
            end
            step();
            tests++; if (bus.stop_ex2rs !== 1'b0) begin failed++; $display("[TB] FAIL mul%0d_stop_post: got %b expected 0", i, bus.stop_ex2rs); end
`else
            bus.valid_rs2ex = 1'b0;
`endif
            tests++; if (bus.result_ex2rob !== exps[i]) begin failed++; $display("[TB] FAIL mul%0d_result: got %h expected %h", i, bus.result_ex2rob, exps[i]); end
            tests++; if (bus.tag_ex2rob !== 6'(7 + i)) begin failed++; $display("[TB] FAIL mul%0d_tag: got %0d expected %0d", i, bus.tag_ex2rob, 7 + i); end
            tests++; if (bus.valid_int2rs !== 1'b1) begin failed++; $display("[TB] FAIL mul%0d_fwd: got %b expected 1", i, bus.valid_int2rs); end
`ifdef INT_EX_MUL_EN
            step();
            bus.valid_rs2ex = 1'b0;
            tests++; if (bus.result_ex2rob !== 64'd42) begin failed++; $display("[TB] FAIL mul%0d_next: got %0d expected 42", i, bus.result_ex2rob); end
            tests++; if (bus.tag_ex2rob !== 6'd20) begin failed++; $display("[TB] FAIL mul%0d_next_tag: got %0d expected 20", i, bus.tag_ex2rob); end
`endif
            step();
        end
    endtask

    task automatic test_reset_mid_mul();
        drive(OP, 3'b000, 12'h000, 6'd9, 6'd9, 64'd100, 64'd200);
        step();
        drive(OP, 3'b000, 12'h020, 6'd10, 6'd10, 64'd3, 64'd5);
        step();
        bus.valid_rs2ex = 1'b0;
        step();
        res_n = 1'b0;
        #1;
        tests++; if (bus.result_ex2rob !== 64'd0) begin failed++; $display("[TB] FAIL midrst_result_rob: got %h expected 0", bus.result_ex2rob); end
        tests++; if (bus.result_int2rs !== 64'd0) begin failed++; $display("[TB] FAIL midrst_result_rs: got %h expected 0", bus.result_int2rs); end
        tests++; if (bus.tag_ex2rob !== 6'd0) begin failed++; $display("[TB] FAIL midrst_tag: got %0d expected 0", bus.tag_ex2rob); end
        tests++; if (bus.rd_int2rs !== 6'd0) begin failed++; $display("[TB] FAIL midrst_rd: got %0d expected 0", bus.rd_int2rs); end
        tests++; if (bus.valid_ex2rob !== 1'b0) begin failed++; $display("[TB] FAIL midrst_valid: got %b expected 0", bus.valid_ex2rob); end
        tests++; if (bus.stop_ex2rs !== 1'b0) begin failed++; $display("[TB] FAIL midrst_stop: got %b expected 0", bus.stop_ex2rs); end
        @(negedge clk);
        res_n = 1'b1;
        drive(OP, 3'b000, 12'h000, 6'd11, 6'd5, 64'd1, 64'd2);
        step();
        bus.valid_rs2ex = 1'b0;
        tests++; if (bus.result_ex2rob !== 64'd3) begin failed++; $display("[TB] FAIL postrst_add: got %0d expected 3", bus.result_ex2rob); end
        tests++; if (bus.tag_ex2rob !== 6'd11) begin failed++; $display("[TB] FAIL postrst_tag: got %0d expected 11", bus.tag_ex2rob); end
        for (int k = 0; k < MUL_LAT + 2; k++) begin
            step();
            tests++; if (bus.valid_ex2rob !== 1'b0 || bus.valid_int2rs !== 1'b0) begin failed++; $display("[TB] FAIL stale_result%0d: got rob=%b rs=%b expected 0 0", k, bus.valid_ex2rob, bus.valid_int2rs); end
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_word_ops();
        test_alu_ops();
        test_stall();
        test_mul();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
